pll_reset_sequencer: RTL and testbench

- Controls the board PLL and turns its lock status into clean, sequenced resets for each PLL output clock domain.
- Sits directly around the PLL: drives its active-high reset input and consumes its asynchronous locked output.
- Runs on the 50 MHz reference clock, which stays valid whether or not the PLL is locked.
- Adds lock debouncing, a lock timeout with automatic PLL re-reset, staggered domain reset release, and loss-of-lock statistics.

---
 rtl/pll_reset_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock: debounces lock,
// retries the PLL on timeout, releases per-domain resets in a stagger, tracks lock losses.
module pll_reset_sequencer #(
  parameter int NUM_DOMAINS         = 4,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 8,
  parameter int CNT_W               = 8
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   clr_status,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   sys_ready,
  output logic [CNT_W-1:0]       relock_count,
  output logic                   timeout_err
);

  localparam int REL_CYCLES = STAGGER_CYCLES * NUM_DOMAINS;
  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD = (LOCK_STABLE_CYCLES > REL_CYCLES) ? LOCK_STABLE_CYCLES : REL_CYCLES;
  localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s, cnt_inc_s;
  logic                   lock_meta_r, lock_sync_r;
  logic                   pll_rst_r, pll_rst_s;
  logic [NUM_DOMAINS-1:0] dom_r, dom_s;
  logic                   ready_r, ready_s;
  logic [CNT_W-1:0]       relock_r, relock_s;
  logic                   terr_r, terr_s;
  logic                   loss_s;

  assign cnt_inc_s    = cnt_r + CW'(1);
  assign pll_rst      = pll_rst_r;
  assign domain_rst_n = dom_r;
  assign sys_ready    = ready_r;
  assign relock_count = relock_r;
  assign timeout_err  = terr_r;

  // Two-flop synchronizer for the asynchronous PLL lock output
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_locked;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Next-state, counter and registered-output computation
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_inc_s;
    pll_rst_s = pll_rst_r;
    dom_s     = dom_r;
    ready_s   = ready_r;
    relock_s  = relock_r;
    terr_s    = terr_r;
    loss_s    = 1'b0;
    case (state_r)
      PLL_RESET: begin
        pll_rst_s = 1'b1;
        dom_s     = '0;
        ready_s   = 1'b0;
        if (cnt_inc_s == CW'(PLL_RST_CYCLES)) begin
          state_s   = WAIT_LOCK;
          cnt_s     = '0;
          pll_rst_s = 1'b0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      WAIT_LOCK: begin
        // lock has priority over a coincident timeout
        if (lock_sync_r) begin
          state_s = STABLE;
          cnt_s   = '0;
        end else if (cnt_inc_s == CW'(LOCK_TIMEOUT_CYCLES)) begin
          state_s   = PLL_RESET;
          cnt_s     = '0;
          pll_rst_s = 1'b1;
          terr_s    = 1'b1;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      STABLE: begin
        if (!lock_sync_r) begin
          state_s = WAIT_LOCK;
          cnt_s   = '0;
        end else if (cnt_inc_s == CW'(LOCK_STABLE_CYCLES)) begin
          state_s = RELEASE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      RELEASE: begin
        if (!lock_sync_r) begin
          loss_s = 1'b1;
        end else if (cnt_r == CW'(REL_CYCLES)) begin
          state_s = RUN;
          cnt_s   = '0;
          ready_s = 1'b1;
        end else begin
          cnt_s = cnt_inc_s;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (cnt_inc_s == CW'(STAGGER_CYCLES * (i + 1))) begin
              dom_s[i] = 1'b1;
            end else begin
              dom_s[i] = dom_r[i];
            end
          end
        end
      end
      RUN: begin
        cnt_s = '0;
        if (!lock_sync_r) begin
          loss_s = 1'b1;
        end else begin
          ready_s = 1'b1;
        end
      end
      default: begin
        state_s   = PLL_RESET;
        cnt_s     = '0;
        pll_rst_s = 1'b1;
        dom_s     = '0;
        ready_s   = 1'b0;
      end
    endcase
    if (loss_s) begin
      state_s   = PLL_RESET;
      cnt_s     = '0;
      pll_rst_s = 1'b1;
      dom_s     = '0;
      ready_s   = 1'b0;
      relock_s  = (relock_r == {CNT_W{1'b1}}) ? relock_r : relock_r + CNT_W'(1);
    end else begin
      relock_s = relock_r;
    end
  end

  // State, counter and output registers; clr_status overrides status updates
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= PLL_RESET;
      cnt_r     <= '0;
      pll_rst_r <= 1'b1;
      dom_r     <= '0;
      ready_r   <= 1'b0;
      relock_r  <= '0;
      terr_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pll_rst_r <= pll_rst_s;
      dom_r     <= dom_s;
      ready_r   <= ready_s;
      relock_r  <= clr_status ? '0 : relock_s;
      terr_r    <= clr_status ? 1'b0 : terr_s;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters; expected values
// are hand-derived cycle positions relative to reset release and lock events.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       clr_status;
  logic       pll_rst;
  logic [3:0] domain_rst_n;
  logic       sys_ready;
  logic [1:0] relock_count;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .NUM_DOMAINS(4), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(64),
    .LOCK_STABLE_CYCLES(8), .STAGGER_CYCLES(2), .CNT_W(2)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .clr_status(clr_status),
    .pll_rst(pll_rst), .domain_rst_n(domain_rst_n), .sys_ready(sys_ready),
    .relock_count(relock_count), .timeout_err(timeout_err)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic p, input logic [3:0] d,
                         input logic r, input logic [1:0] c, input logic t);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'(p));
    chk({tag, "_dom"}, 32'(domain_rst_n), 32'(d));
    chk({tag, "_ready"}, 32'(sys_ready), 32'(r));
    chk({tag, "_relock"}, 32'(relock_count), 32'(c));
    chk({tag, "_terr"}, 32'(timeout_err), 32'(t));
  endtask

  initial begin
    logic [1:0] exp_cnt [4];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
    rst_n = 1'b0; pll_locked = 1'b0; clr_status = 1'b0;

    // reset state
    tick(2);
    chk_all("reset", 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);

    // power-up: release, pll_rst high for 4 cycles (edges E1..E3), low at E4
    rst_n = 1'b1;
    tick(3);
    chk("pwr_rst_hi", 32'(pll_rst), 32'd1);
    tick(1);
    chk("pwr_rst_lo", 32'(pll_rst), 32'd0);
    tick(1);                      // E5
    pll_locked = 1'b1;            // STABLE at E8, RELEASE entry E16
    tick(10);                     // E15
    chk("pwr_dom_e15", 32'(domain_rst_n), 32'h0);
    tick(1);
    chk("pwr_dom_e16", 32'(domain_rst_n), 32'h0);
    tick(1);
    chk("pwr_dom_e17", 32'(domain_rst_n), 32'h0);
    tick(1);
    chk("pwr_dom_e18", 32'(domain_rst_n), 32'h1);
    tick(2);
    chk("pwr_dom_e20", 32'(domain_rst_n), 32'h3);
    tick(2);
    chk("pwr_dom_e22", 32'(domain_rst_n), 32'h7);
    tick(2);
    chk("pwr_dom_e24", 32'(domain_rst_n), 32'hf);
    chk("pwr_ready_e24", 32'(sys_ready), 32'd0);
    tick(1);
    chk_all("pwr_run", 1'b0, 4'b1111, 1'b1, 2'd0, 1'b0);

    // loss in RUN: visible 3 edges after the drop
    pll_locked = 1'b0;
    tick(2);
    chk("loss_ready_e27", 32'(sys_ready), 32'd1);
    tick(1);                      // E28: PLL_RESET entry
    chk_all("loss1", 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0);

    // timeout: WAIT_LOCK entry E32, timeout fires at E96
    tick(4);
    chk("to_wait_e32", 32'(pll_rst), 32'd0);
    tick(63);
    chk("to_e95_rst", 32'(pll_rst), 32'd0);
    chk("to_e95_terr", 32'(timeout_err), 32'd0);
    tick(1);
    chk("to_e96_rst", 32'(pll_rst), 32'd1);
    chk("to_e96_terr", 32'(timeout_err), 32'd1);
    tick(3);
    chk("to_e99_rst", 32'(pll_rst), 32'd1);
    tick(1);                      // E100: back in WAIT_LOCK
    chk("to_e100_rst", 32'(pll_rst), 32'd0);
    chk("to_e100_terr", 32'(timeout_err), 32'd1);

    // unstable lock: 5-cycle pulse breaks STABLE at E108, then steady lock
    pll_locked = 1'b1;
    tick(5);                      // E105
    pll_locked = 1'b0;
    tick(5);                      // E110
    chk("unst_dom_e110", 32'(domain_rst_n), 32'h0);
    pll_locked = 1'b1;            // STABLE at E113, RELEASE entry E121
    tick(10);                     // E120
    chk("unst_dom_e120", 32'(domain_rst_n), 32'h0);
    tick(2);
    chk("unst_dom_e122", 32'(domain_rst_n), 32'h0);
    tick(1);
    chk("unst_dom_e123", 32'(domain_rst_n), 32'h1);
    tick(6);
    chk("unst_dom_e129", 32'(domain_rst_n), 32'hf);
    tick(1);
    chk_all("unst_run", 1'b0, 4'b1111, 1'b1, 2'd1, 1'b1);

    // clear collides with lock-loss detection at E133
    pll_locked = 1'b0;
    tick(2);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    chk_all("clr_coll", 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);

    // repeated losses: lock raised at PLL_RESET entry L, ready at L+22, loss at L+25
    for (int n = 0; n < 4; n++) begin
      pll_locked = 1'b1;
      tick(21);
      chk("rep_ready_pre", 32'(sys_ready), 32'd0);
      tick(1);
      chk("rep_ready", 32'(sys_ready), 32'd1);
      chk("rep_dom", 32'(domain_rst_n), 32'hf);
      pll_locked = 1'b0;
      tick(2);
      chk("rep_ready_hold", 32'(sys_ready), 32'd1);
      tick(1);
      chk_all("rep_loss", 1'b1, 4'b0000, 1'b0, exp_cnt[n], 1'b0);
    end

    // async reset mid-RELEASE with domain_rst_n = 0011 (RELEASE entry at L+13)
    pll_locked = 1'b1;
    tick(17);
    chk("ar_dom_0011", 32'(domain_rst_n), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("ar_async", 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("ar_restart_hi", 32'(pll_rst), 32'd1);
    tick(1);
    chk("ar_restart_lo", 32'(pll_rst), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
